id_ex_stage: RTL

- ID/EX pipeline register with load-use hazard detection, bubble insertion, branch flush and WB-to-ID bypass.
- Sits between the decode stage and the EX-stage forwarding unit.
- Its registered rs/rt, write address/enable and bus1/bus2 outputs are the ID_EX_* inputs that the forwarding unit consumes.

---
 rtl/id_ex_stage_pkg.sv | 35 +++
 rtl/id_ex_stage_hazard_detect.sv | 37 +++
 rtl/id_ex_stage.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline stage: ALU opcodes, architectural
// register constants and the control bundle carried from decode into execute.
package id_ex_stage_pkg;

    localparam int ALUOP_W = 5;

    localparam logic [ALUOP_W-1:0] ALU_ADD  = 5'd0;
    localparam logic [ALUOP_W-1:0] ALU_SUB  = 5'd1;
    localparam logic [ALUOP_W-1:0] ALU_AND  = 5'd2;
    localparam logic [ALUOP_W-1:0] ALU_OR   = 5'd3;
    localparam logic [ALUOP_W-1:0] ALU_XOR  = 5'd4;
    localparam logic [ALUOP_W-1:0] ALU_NOR  = 5'd5;
    localparam logic [ALUOP_W-1:0] ALU_SLT  = 5'd6;
    localparam logic [ALUOP_W-1:0] ALU_SLTU = 5'd7;
    localparam logic [ALUOP_W-1:0] ALU_SLL  = 5'd8;
    localparam logic [ALUOP_W-1:0] ALU_SRL  = 5'd9;
    localparam logic [ALUOP_W-1:0] ALU_SRA  = 5'd10;
    localparam logic [ALUOP_W-1:0] ALU_LUI  = 5'd11;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    // Field order is fixed: downstream stages slice this bundle positionally.
    typedef struct packed {
        logic               reg_wr;
        logic               mem_rd;
        logic               mem_wr;
        logic               mem_to_reg;
        logic               alu_src;
        logic [ALUOP_W-1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection and the resulting PC / IF-ID write enables.
// Purely combinational; register 0 never creates a hazard.
module hazard_detect #(
    parameter int AW = 5
) (
    input  logic          i_ex_valid,
    input  logic          i_ex_mem_rd,
    input  logic [AW-1:0] i_ex_wr_addr,
    input  logic [AW-1:0] i_rs,
    input  logic [AW-1:0] i_rt,
    input  logic          i_uses_rt,
    input  logic          i_flush,
    input  logic          i_hold,
    output logic          o_load_use,
    output logic          o_pc_wr,
    output logic          o_if_id_wr
);
    import id_ex_stage_pkg::*;

    logic w_hit_rs;
    logic w_hit_rt;
    logic w_load_use;
    logic w_front_wr;

    assign w_hit_rs   = (i_ex_wr_addr == i_rs);
    assign w_hit_rt   = i_uses_rt && (i_ex_wr_addr == i_rt);
    assign w_load_use = i_ex_valid && i_ex_mem_rd &&
                        (i_ex_wr_addr != AW'(REG_ZERO)) && (w_hit_rs || w_hit_rt);

    // A flush discards the dependent instruction anyway, so it releases the stall.
    assign w_front_wr = !(i_hold || (w_load_use && !i_flush));

    assign o_load_use = w_load_use;
    assign o_pc_wr    = w_front_wr;
    assign o_if_id_wr = w_front_wr;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush,
// downstream hold and a WB-to-ID bypass on the register-file read data.
module id_ex_stage #(
    parameter int DW        = 32,
    parameter int AW        = 5,
    parameter int ALUOP_W   = 5,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [AW-1:0]      IF_ID_rs,
    input  logic [AW-1:0]      IF_ID_rt,
    input  logic               ID_uses_rt,
    input  logic               ID_reg_wr,
    input  logic [AW-1:0]      ID_reg_wr_addr,
    input  logic               ID_mem_rd,
    input  logic               ID_mem_wr,
    input  logic               ID_mem_to_reg,
    input  logic [ALUOP_W-1:0] ID_alu_op,
    input  logic               ID_alu_src,
    input  logic [DW-1:0]      ID_bus1,
    input  logic [DW-1:0]      ID_bus2,
    input  logic [DW-1:0]      ID_imm,
    input  logic [DW-1:0]      ID_pc_plus4,
    input  logic               MEM_WB_reg_wr,
    input  logic [AW-1:0]      MEM_WB_reg_wr_addr,
    input  logic [DW-1:0]      MEM_WB_reg_wr_data,
    input  logic               EX_flush,
    input  logic               EX_hold,
    output logic [AW-1:0]      ID_EX_rs,
    output logic [AW-1:0]      ID_EX_rt,
    output logic               ID_EX_reg_wr,
    output logic [AW-1:0]      ID_EX_reg_wr_addr,
    output logic               ID_EX_mem_rd,
    output logic               ID_EX_mem_wr,
    output logic               ID_EX_mem_to_reg,
    output logic               ID_EX_alu_src,
    output logic [ALUOP_W-1:0] ID_EX_alu_op,
    output logic [DW-1:0]      ID_EX_bus1,
    output logic [DW-1:0]      ID_EX_bus2,
    output logic [DW-1:0]      ID_EX_imm,
    output logic [DW-1:0]      ID_EX_pc_plus4,
    output logic               ID_EX_valid,
    output logic               PC_wr,
    output logic               IF_ID_wr
);
    import id_ex_stage_pkg::*;

    ctrl_t         r_ctrl;
    logic [AW-1:0] r_rs;
    logic [AW-1:0] r_rt;
    logic [AW-1:0] r_wr_addr;
    logic [DW-1:0] r_bus1;
    logic [DW-1:0] r_bus2;
    logic [DW-1:0] r_imm;
    logic [DW-1:0] r_pc_plus4;
    logic          r_valid;

    logic          w_load_use;
    logic          w_bubble;
    logic          w_capture;
    logic [DW-1:0] w_bus1_nxt;
    logic [DW-1:0] w_bus2_nxt;
    ctrl_t         w_ctrl_in;

    hazard_detect #(
        .AW (AW)
    ) u_hazard_detect (
        .i_ex_valid   (r_valid),
        .i_ex_mem_rd  (r_ctrl.mem_rd),
        .i_ex_wr_addr (r_wr_addr),
        .i_rs         (IF_ID_rs),
        .i_rt         (IF_ID_rt),
        .i_uses_rt    (ID_uses_rt),
        .i_flush      (EX_flush),
        .i_hold       (EX_hold),
        .o_load_use   (w_load_use),
        .o_pc_wr      (PC_wr),
        .o_if_id_wr   (IF_ID_wr)
    );

    // Slot semantics: r_valid marks a real instruction. Flush wins over hold,
    // hold freezes the slot, a load-use hazard injects a bubble, else capture.
    assign w_bubble  = EX_flush || (!EX_hold && w_load_use);
    assign w_capture = !EX_flush && !EX_hold && !w_load_use;

    assign w_ctrl_in.reg_wr     = ID_reg_wr;
    assign w_ctrl_in.mem_rd     = ID_mem_rd;
    assign w_ctrl_in.mem_wr     = ID_mem_wr;
    assign w_ctrl_in.mem_to_reg = ID_mem_to_reg;
    assign w_ctrl_in.alu_src    = ID_alu_src;
    assign w_ctrl_in.alu_op     = ID_alu_op;

    generate
        if (WB_BYPASS) begin : g_wb_bypass
            logic w_wb_live;
            // The regfile write lands this same edge, so ID would read stale data.
            assign w_wb_live  = MEM_WB_reg_wr && (MEM_WB_reg_wr_addr != AW'(REG_ZERO));
            assign w_bus1_nxt = (w_wb_live && MEM_WB_reg_wr_addr == IF_ID_rs) ?
                                MEM_WB_reg_wr_data : ID_bus1;
            assign w_bus2_nxt = (w_wb_live && MEM_WB_reg_wr_addr == IF_ID_rt) ?
                                MEM_WB_reg_wr_data : ID_bus2;
        end else begin : g_no_bypass
            assign w_bus1_nxt = ID_bus1;
            assign w_bus2_nxt = ID_bus2;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl     <= CTRL_BUBBLE;
            r_rs       <= '0;
            r_rt       <= '0;
            r_wr_addr  <= '0;
            r_bus1     <= '0;
            r_bus2     <= '0;
            r_imm      <= '0;
            r_pc_plus4 <= '0;
            r_valid    <= 1'b0;
        end else if (w_bubble) begin
            r_ctrl     <= CTRL_BUBBLE;
            r_rs       <= '0;
            r_rt       <= '0;
            r_wr_addr  <= '0;
            r_bus1     <= '0;
            r_bus2     <= '0;
            r_imm      <= '0;
            r_pc_plus4 <= '0;
            r_valid    <= 1'b0;
        end else if (w_capture) begin
            r_ctrl     <= w_ctrl_in;
            r_rs       <= IF_ID_rs;
            r_rt       <= IF_ID_rt;
            r_wr_addr  <= ID_reg_wr_addr;
            r_bus1     <= w_bus1_nxt;
            r_bus2     <= w_bus2_nxt;
            r_imm      <= ID_imm;
            r_pc_plus4 <= ID_pc_plus4;
            r_valid    <= 1'b1;
        end
    end

    assign ID_EX_rs          = r_rs;
    assign ID_EX_rt          = r_rt;
    assign ID_EX_reg_wr      = r_ctrl.reg_wr;
    assign ID_EX_reg_wr_addr = r_wr_addr;
    assign ID_EX_mem_rd      = r_ctrl.mem_rd;
    assign ID_EX_mem_wr      = r_ctrl.mem_wr;
    assign ID_EX_mem_to_reg  = r_ctrl.mem_to_reg;
    assign ID_EX_alu_src     = r_ctrl.alu_src;
    assign ID_EX_alu_op      = r_ctrl.alu_op;
    assign ID_EX_bus1        = r_bus1;
    assign ID_EX_bus2        = r_bus2;
    assign ID_EX_imm         = r_imm;
    assign ID_EX_pc_plus4    = r_pc_plus4;
    assign ID_EX_valid       = r_valid;

endmodule
